// File: rtl/button_debouncer.sv
// Per-channel button debouncer with one-cycle press pulses and registered level/held outputs.
// Hold-to-repeat pulses are built only when AUTOREPEAT_EN is defined; otherwise held_out is tied 0.
module button_debouncer #(
   parameter int CHANNELS      = 4,
   parameter int CNT_WIDTH     = 20,
   parameter int DEB_CYCLES    = 5000,
   parameter int REPEAT_DELAY  = 500000,
   parameter int REPEAT_PERIOD = 100000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] btn_in,
   output logic [CHANNELS-1:0] level_out,
   output logic [CHANNELS-1:0] pulse_out,
   output logic [CHANNELS-1:0] held_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_PRESSED,
`ifdef AUTOREPEAT_EN
      S_REPEAT,
`endif
      S_RELEASE
   } state_t;

   localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEB_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
`ifdef AUTOREPEAT_EN
   localparam logic [CNT_WIDTH-1:0] RPT_DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
   localparam logic [CNT_WIDTH-1:0] RPT_PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      state_t               state_q;
      logic [CNT_WIDTH-1:0] cnt_q;
      logic [CNT_WIDTH-1:0] cnt_inc;
      logic                 level_q;
      logic                 pulse_q;
`ifdef AUTOREPEAT_EN
      logic                 held_q;
`endif

      // Saturating increment: a long hold must never wrap back into a match.
      assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;

      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
`ifdef AUTOREPEAT_EN
            held_q  <= 1'b0;
`endif
         end else begin
            pulse_q <= 1'b0;
            case (state_q)
               S_IDLE: begin
                  if (btn_in[g]) begin
                     state_q <= S_ARM;
                     cnt_q   <= CNT_ONE;
                  end
               end
               S_ARM: begin
                  if (!btn_in[g]) begin
                     state_q <= S_IDLE;
                     cnt_q   <= '0;
                  end else if (cnt_q == DEB_LAST) begin
                     state_q <= S_PRESSED;
                     cnt_q   <= '0;
                     level_q <= 1'b1;
                     pulse_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
               S_PRESSED: begin
                  if (!btn_in[g]) begin
                     state_q <= S_RELEASE;
                     cnt_q   <= CNT_ONE;
`ifdef AUTOREPEAT_EN
                  end else if (cnt_q == RPT_DELAY_LAST) begin
                     state_q <= S_REPEAT;
                     cnt_q   <= '0;
                     pulse_q <= 1'b1;
                     held_q  <= 1'b1;
`endif
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
`ifdef AUTOREPEAT_EN
               S_REPEAT: begin
                  if (!btn_in[g]) begin
                     state_q <= S_RELEASE;
                     cnt_q   <= CNT_ONE;
                     held_q  <= 1'b0;
                  end else if (cnt_q == RPT_PERIOD_LAST) begin
                     cnt_q   <= '0;
                     pulse_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
`endif
               S_RELEASE: begin
                  // A 1 here is release bounce: back to PRESSED silently, repeat timing restarts.
                  if (btn_in[g]) begin
                     state_q <= S_PRESSED;
                     cnt_q   <= '0;
                  end else if (cnt_q == DEB_LAST) begin
                     state_q <= S_IDLE;
                     cnt_q   <= '0;
                     level_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  level_q <= 1'b0;
               end
            endcase
         end
      end

      assign level_out[g] = level_q;
      assign pulse_out[g] = pulse_q;
`ifdef AUTOREPEAT_EN
      assign held_out[g]  = held_q;
`else
      assign held_out[g]  = 1'b0;
`endif
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: constant vector table, directed hold/reset sequences, random bounce vs run-length model.
module tb_button_debouncer;

   localparam int NCH = 4;
   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RP  = 3;
`ifdef AUTOREPEAT_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic [NCH-1:0] btn_in;
   logic [NCH-1:0] level_out, pulse_out, held_out;

   int checks   = 0;
   int failures = 0;

   button_debouncer #(
      .CHANNELS(NCH), .CNT_WIDTH(8), .DEB_CYCLES(DEB),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk), .reset(reset), .btn_in(btn_in),
      .level_out(level_out), .pulse_out(pulse_out), .held_out(held_out)
   );

   always #5 clk = ~clk;

   // Reference model: run lengths of identical samples plus count of held samples since press.
   int             run0 [NCH];
   int             run1 [NCH];
   int             hcnt [NCH];
   logic [NCH-1:0] m_level = '0, m_pulse = '0, m_held = '0;
   logic [NCH-1:0] prev_pulse = '0;

   task automatic model(input logic r, input logic [NCH-1:0] b);
      for (int ch = 0; ch < NCH; ch++) begin
         if (r) begin
            run0[ch] = 0; run1[ch] = 0; hcnt[ch] = 0;
            m_level[ch] = 1'b0; m_pulse[ch] = 1'b0; m_held[ch] = 1'b0;
         end else begin
            bit prev_zero;
            prev_zero = (run0[ch] > 0);
            m_pulse[ch] = 1'b0;
            if (b[ch]) begin run1[ch]++; run0[ch] = 0; end
            else       begin run0[ch]++; run1[ch] = 0; end
            if (!m_level[ch]) begin
               if (run1[ch] == DEB) begin
                  m_level[ch] = 1'b1; m_pulse[ch] = 1'b1; hcnt[ch] = 0;
               end
            end else if (b[ch]) begin
               if (prev_zero) hcnt[ch] = 0;
               else begin
                  hcnt[ch]++;
                  if (AR && hcnt[ch] >= RD && (hcnt[ch] - RD) % RP == 0) m_pulse[ch] = 1'b1;
                  m_held[ch] = AR && (hcnt[ch] >= RD);
               end
            end else begin
               m_held[ch] = 1'b0;
               if (run0[ch] == DEB) m_level[ch] = 1'b0;
            end
         end
      end
   endtask

   task automatic check(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input logic r, input logic [NCH-1:0] b);
      reset  = r;
      btn_in = b;
      model(r, b);
      @(posedge clk);
      #1;
      check("model_level", level_out, m_level);
      check("model_pulse", pulse_out, m_pulse);
      check("model_held", held_out, m_held);
      check("no_back_to_back", pulse_out & prev_pulse, '0);
      prev_pulse = pulse_out;
   endtask

   typedef struct {
      logic           rst;
      logic [NCH-1:0] btn;
      logic [NCH-1:0] lvl;
      logic [NCH-1:0] pls;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic r, input logic [NCH-1:0] b,
                               input logic [NCH-1:0] l, input logic [NCH-1:0] p);
      vec_t v;
      v.rst = r; v.btn = b; v.lvl = l; v.pls = p;
      return v;
   endfunction

   initial begin
      reset  = 1'b1;
      btn_in = '0;

      // Reset hold with all buttons pressed, then 4 clean samples, then clean release.
      vt.push_back(mk(1, 4'hF, 4'h0, 4'h0));
      vt.push_back(mk(1, 4'hF, 4'h0, 4'h0));
      vt.push_back(mk(1, 4'hF, 4'h0, 4'h0));
      vt.push_back(mk(0, 4'hF, 4'h0, 4'h0));
      vt.push_back(mk(0, 4'hF, 4'h0, 4'h0));
      vt.push_back(mk(0, 4'hF, 4'h0, 4'h0));
      vt.push_back(mk(0, 4'hF, 4'hF, 4'hF));
      vt.push_back(mk(0, 4'h0, 4'hF, 4'h0));
      vt.push_back(mk(0, 4'h0, 4'hF, 4'h0));
      vt.push_back(mk(0, 4'h0, 4'hF, 4'h0));
      vt.push_back(mk(0, 4'h0, 4'h0, 4'h0));
      // Clean press on ch0 for 6 cycles, then release.
      vt.push_back(mk(0, 4'h1, 4'h0, 4'h0));
      vt.push_back(mk(0, 4'h1, 4'h0, 4'h0));
      vt.push_back(mk(0, 4'h1, 4'h0, 4'h0));
      vt.push_back(mk(0, 4'h1, 4'h1, 4'h1));
      vt.push_back(mk(0, 4'h1, 4'h1, 4'h0));
      vt.push_back(mk(0, 4'h1, 4'h1, 4'h0));
      vt.push_back(mk(0, 4'h0, 4'h1, 4'h0));
      vt.push_back(mk(0, 4'h0, 4'h1, 4'h0));
      vt.push_back(mk(0, 4'h0, 4'h1, 4'h0));
      vt.push_back(mk(0, 4'h0, 4'h0, 4'h0));
      // Bouncy press on ch1: 1,1,0,1,1,1,1 then bouncy release 0,1,0,0,0,0.
      vt.push_back(mk(0, 4'h2, 4'h0, 4'h0));
      vt.push_back(mk(0, 4'h2, 4'h0, 4'h0));
      vt.push_back(mk(0, 4'h0, 4'h0, 4'h0));
      vt.push_back(mk(0, 4'h2, 4'h0, 4'h0));
      vt.push_back(mk(0, 4'h2, 4'h0, 4'h0));
      vt.push_back(mk(0, 4'h2, 4'h0, 4'h0));
      vt.push_back(mk(0, 4'h2, 4'h2, 4'h2));
      vt.push_back(mk(0, 4'h0, 4'h2, 4'h0));
      vt.push_back(mk(0, 4'h2, 4'h2, 4'h0));
      vt.push_back(mk(0, 4'h0, 4'h2, 4'h0));
      vt.push_back(mk(0, 4'h0, 4'h2, 4'h0));
      vt.push_back(mk(0, 4'h0, 4'h2, 4'h0));
      vt.push_back(mk(0, 4'h0, 4'h0, 4'h0));

      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].rst, vt[i].btn);
         check("tbl_level", level_out, vt[i].lvl);
         check("tbl_pulse", pulse_out, vt[i].pls);
         check("tbl_held", held_out, 4'h0);
      end

      // 30-cycle hold on ch2: first pulse at sample 4, repeats only with autorepeat.
      for (int i = 1; i <= 30; i++) begin
         logic exp_p, exp_h;
         exp_p = (i == DEB) || (AR && i >= DEB + RD && (i - DEB - RD) % RP == 0);
         exp_h = AR && (i >= DEB + RD);
         step(1'b0, 4'h4);
         check("hold_pulse", pulse_out, {1'b0, exp_p, 2'b00});
         check("hold_held", held_out, {1'b0, exp_h, 2'b00});
      end
      for (int j = 1; j <= DEB; j++) begin
         step(1'b0, 4'h0);
         check("hold_rel_held", held_out, 4'h0);
         check("hold_rel_level", level_out, (j < DEB) ? 4'h4 : 4'h0);
      end

      // Reset in the middle of a repeat on ch3, button kept pressed through and after reset.
      for (int i = 1; i <= DEB + RD; i++) step(1'b0, 4'h8);
      check("mid_held", held_out, AR ? 4'h8 : 4'h0);
      check("mid_level", level_out, 4'h8);
      step(1'b1, 4'h8);
      check("rst_level", level_out, 4'h0);
      check("rst_pulse", pulse_out, 4'h0);
      check("rst_held", held_out, 4'h0);
      for (int i = 1; i <= DEB; i++) begin
         step(1'b0, 4'h8);
         check("post_rst_pulse", pulse_out, (i == DEB) ? 4'h8 : 4'h0);
      end
      for (int i = 0; i < DEB; i++) step(1'b0, 4'h0);

      // Random bouncing buttons with occasional reset, checked against the model only.
      begin
         logic [NCH-1:0] b;
         b = '0;
         for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < NCH; ch++)
               if ($urandom_range(0, 11) == 0) b[ch] = ~b[ch];
            step($urandom_range(0, 299) == 0, b);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
